wave_meter: RTL

WAVE_METER -- requirements
Module: wave_meter

---
 rtl/wave_meter_if.sv | 19 +
 rtl/wave_meter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wave_meter_if.sv
// Sample stream in, period/peak-to-peak measurements out, for wave_meter.
interface wave_meter_if;
   logic [11:0] sample_in;
   logic        sample_vld;
   logic [25:0] meas_period;
   logic [11:0] meas_vpp;
   logic        meas_vld;
   logic        meas_timeout;

   modport master (
      output sample_in, sample_vld,
      input  meas_period, meas_vpp, meas_vld, meas_timeout
   );

   modport slave (
      input  sample_in, sample_vld,
      output meas_period, meas_vpp, meas_vld, meas_timeout
   );
endinterface

// File: rtl/wave_meter.sv
// Measures waveform period (in valid samples) and peak-to-peak between hysteretic rising crossings.
// Optional WAVE_METER_AVG_EN: report the mean of the last 4 periods instead of the last one.
module wave_meter #(
   parameter logic [11:0] MID     = 12'd2048,
   parameter logic [11:0] HYST    = 12'd64,
   parameter logic [25:0] TIMEOUT = 26'd50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   wave_meter_if.slave bus_io
);

   typedef enum logic [1:0] {StArmLow, StArmHigh, StMeasHigh, StMeasLow} state_e;

   localparam logic [12:0] HighThr = {1'b0, MID} + {1'b0, HYST};

   state_e      state_q, state_d;
   logic [25:0] cnt_q, cnt_d;
   logic [11:0] max_q, max_d, min_q, min_d;
   logic [25:0] period_q, period_d;
   logic [11:0] vpp_q, vpp_d;
   logic        vld_q, vld_d, tout_q, tout_d;

   logic [11:0] s;
   logic        vld, is_high, is_low, in_meas, rise, first_rise, tout_ev;

   assign s       = bus_io.sample_in;
   assign vld     = bus_io.sample_vld;
   assign is_high = {1'b0, s} >= HighThr;
   // Add instead of subtract so a large HYST cannot underflow.
   assign is_low  = ({1'b0, s} + {1'b0, HYST}) <= {1'b0, MID};
   assign in_meas = (state_q == StMeasHigh) || (state_q == StMeasLow);
   assign rise       = vld && (state_q == StMeasLow) && is_high;
   assign first_rise = vld && (state_q == StArmHigh) && is_high;
   assign tout_ev    = vld && in_meas && !rise && (cnt_q == TIMEOUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StArmLow;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (vld) begin
         case (state_q)
            StArmLow:   if (is_low) state_d = StArmHigh;
            StArmHigh:  if (is_high) state_d = StMeasHigh;
            StMeasHigh: begin
               if (tout_ev)     state_d = StArmLow;
               else if (is_low) state_d = StMeasLow;
            end
            StMeasLow: begin
               if (is_high)      state_d = StMeasHigh;
               else if (tout_ev) state_d = StArmLow;
            end
            default:    state_d = StArmLow;
         endcase
      end
   end

`ifdef WAVE_METER_AVG_EN
   logic [2:0][25:0] hist_q, hist_d;
   logic [1:0]       coll_q, coll_d;
   logic [27:0]      sum;

   assign sum = {2'b0, hist_q[0]} + {2'b0, hist_q[1]} + {2'b0, hist_q[2]} + {2'b0, cnt_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         coll_q <= '0;
      end else begin
         hist_q <= hist_d;
         coll_q <= coll_d;
      end
   end
`endif

   always_comb begin
      cnt_d    = cnt_q;
      max_d    = max_q;
      min_d    = min_q;
      period_d = period_q;
      vpp_d    = vpp_q;
      vld_d    = 1'b0;
      tout_d   = tout_q;
`ifdef WAVE_METER_AVG_EN
      hist_d   = hist_q;
      coll_d   = coll_q;
`endif
      if (first_rise || rise) begin
         cnt_d = 26'd1;
         max_d = s;
         min_d = s;
      end else if (tout_ev) begin
         cnt_d  = '0;
         tout_d = 1'b1;
`ifdef WAVE_METER_AVG_EN
         coll_d = '0;
`endif
      end else if (vld && in_meas) begin
         cnt_d = cnt_q + 26'd1;
         if (s > max_q) max_d = s;
         if (s < min_q) min_d = s;
      end

      if (rise) begin
         tout_d = 1'b0;
`ifdef WAVE_METER_AVG_EN
         hist_d = {hist_q[1], hist_q[0], cnt_q};
         // History holds 3 older periods; the 4th is the one just closed.
         if (coll_q == 2'd3) begin
            vld_d    = 1'b1;
            period_d = sum[27:2];
            vpp_d    = max_q - min_q;
         end else begin
            coll_d = coll_q + 2'd1;
         end
`else
         vld_d    = 1'b1;
         period_d = cnt_q;
         vpp_d    = max_q - min_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         max_q    <= '0;
         min_q    <= 12'hFFF;
         period_q <= '0;
         vpp_q    <= '0;
         vld_q    <= 1'b0;
         tout_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         max_q    <= max_d;
         min_q    <= min_d;
         period_q <= period_d;
         vpp_q    <= vpp_d;
         vld_q    <= vld_d;
         tout_q   <= tout_d;
      end
   end

   assign bus_io.meas_period  = period_q;
   assign bus_io.meas_vpp     = vpp_q;
   assign bus_io.meas_vld     = vld_q;
   assign bus_io.meas_timeout = tout_q;

endmodule
